ula_multiciclo: RTL and testbench
=================================

// Module: ula_multiciclo
// PURPOSE
//  Parametrised multi-cycle ALU with built-in operation decode; successor to the 2-bit ULA control decoder.
//  Decodes ULAOp/Funct/Ext, executes on WIDTH-bit operands and reports result and flags under a start/done handshake.
//  Sits in the nRISC EX stage; the control FSM stalls the datapath while busy is high.
//  Ext=0 keeps the legacy op map unchanged. Ext=1 unlocks iterative shift and multiply.
// PARAMETERS
//  WIDTH    8                 operand/result width (>=4)
//  SHAMT_W  $clog2(WIDTH)     shift-amount bits, taken from B[SHAMT_W-1:0]
// PORTS
//  clock     in   1        system clock, all state on rising edge
//  reset     in   1        synchronous, active-high
//  start     in   1        accept operation this cycle; sampled only when busy=0
//  ULAOp     in   2        op class from main control
//  Funct     in   1        op select within class
//  Ext       in   1        0=legacy map, 1=extended ops
//  A, B      in   WIDTH    operands, captured on accepted start
//  result    out  WIDTH    registered result, held until next accepted start
//  zero      out  1        result==0, registered with result
//  overflow  out  1        signed overflow of ADD/SUB, else 0
//  busy      out  1        high from cycle after accepted start until done cycle (exclusive)
//  done      out  1        one-cycle pulse, result/flags valid from this cycle
// BEHAVIOUR
//  Reset: result=0, zero=0, overflow=0, busy=0, done=0, FSM=IDLE, counters=0. Reset mid-op aborts, no done pulse.
//  Decode (Ext=0): 00/F0 ADD, 00/F1 SUB, 01/F0 SLT (signed, result={0..,1}), 01/F1 NOT A, 10/x and 11/x ADD.
//  Decode (Ext=1): 00,01 as Ext=0; 10/F0 SLL A by B[SHAMT_W-1:0]; 10/F1 SRL (logical); 11/F0 MUL; 11/F1 ADD.
//  Start while busy=1: ignored entirely (operands, op not captured).
//  FSM states: IDLE, SHIFT, MUL, FIN.
//   IDLE + start, single-cycle op (ADD/SUB/SLT/NOT) -> compute, load result -> FIN. done at cycle 1, busy never high.
//   IDLE + start, SLL/SRL, amount n: n=0 -> result=A -> FIN. n>0 -> SHIFT, 1 bit/cycle, n cycles -> FIN. done at cycle n+1.
//   IDLE + start, MUL -> MUL, shift-add 1 bit of B/cycle, WIDTH cycles -> FIN. done at cycle WIDTH+1.
//   FIN: done=1 for one cycle -> IDLE. start accepted in FIN cycle's successor (IDLE) only.
//  Cycle numbering: start sampled at edge 0, done high after edge k as listed.
//  Arithmetic: ADD/SUB modulo 2^WIDTH. MUL keeps low WIDTH bits (unsigned == signed low half). overflow=0 for non ADD/SUB.
//  Flags and result update together on the done cycle. Intermediate shift/mul values are not visible on result.
//  busy=1 in SHIFT and MUL only. done and busy are never high together.
// CONFIGURATION
//  ULA_MUL_EN defined: 11/F1 with Ext=1... 11/F0 with Ext=1 executes MUL as above.
//  ULA_MUL_EN undefined: 11/F0 with Ext=1 decodes as ADD (1-cycle). MUL state, multiplier datapath and counter width not synthesised.
//  All other ops identical in both builds.
// TESTING (WIDTH=8)
//  ADD Ext=0 ULAOp=00 F=0, A=8'h7F B=8'h01 -> done at cycle 1, result=8'h80, overflow=1, zero=0, busy stays 0.
//  SUB A=8'h05 B=8'h05; then SLT A=8'hFE B=8'h01 -> result=8'h00 zero=1; then result=8'h01 zero=0.
//  SLL Ext=1 A=8'h81 B=8'h03 -> busy cycles 1..3, done cycle 4, result=8'h08. SRL B=0 -> done cycle 1, result=A.
//  MUL Ext=1 A=8'd13 B=8'd11 -> done cycle 9, result=8'h8F. Without ULA_MUL_EN -> done cycle 1, result=8'h18.
//  Legacy Ext=0 ULAOp=10, A=3 B=4 -> result=7 at cycle 1. start pulsed during busy of a MUL -> ignored, MUL result unchanged.
//  reset asserted at cycle 3 of a MUL -> next edge busy=0, result=0, no done. Fresh ADD 2+2 afterwards -> result=4 at cycle 1.

Source files
------------

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multi-cycle ALU with built-in ULAOp/Funct/Ext decode and a start/done handshake.
// Optional build macro ULA_MUL_EN enables the iterative shift-add multiplier (11/F0 with Ext=1).
`default_nettype none

module ula_multiciclo #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ULAOp,
    input  logic             Funct,
    input  logic             Ext,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SLT = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_SLL = 3'd4;
    localparam logic [2:0] OP_SRL = 3'd5;

`ifdef ULA_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [2:0] OP_MUL = 3'd6;
    // Counter must hold WIDTH itself for the multiply loop.
    localparam int CNT_W = $clog2(WIDTH + 1);
`else
    localparam int CNT_W = SHAMT_W;
`endif

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2:0]         op_w;
    logic [WIDTH-1:0]   alu_w;
    logic               alu_ovf_w;
    logic [WIDTH-1:0]   sum_w, diff_w;
    logic [WIDTH-1:0]   sh_next_w;
    logic [SHAMT_W-1:0] shamt_w;

`ifdef ULA_MUL_EN
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_next_w;

    assign acc_next_w = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    assign shamt_w   = B[SHAMT_W-1:0];
    assign sum_w     = A + B;
    assign diff_w    = A - B;
    assign sh_next_w = dir_q ? (sh_q >> 1) : (sh_q << 1);

    always_comb begin
        op_w = OP_ADD;
        case (ULAOp)
            2'b00: op_w = Funct ? OP_SUB : OP_ADD;
            2'b01: op_w = Funct ? OP_NOT : OP_SLT;
            2'b10: if (Ext) op_w = Funct ? OP_SRL : OP_SLL;
`ifdef ULA_MUL_EN
            2'b11: if (Ext && !Funct) op_w = OP_MUL;
`endif
            default: op_w = OP_ADD;
        endcase
    end

    always_comb begin
        alu_w     = sum_w;
        alu_ovf_w = (A[WIDTH-1] == B[WIDTH-1]) && (sum_w[WIDTH-1] != A[WIDTH-1]);
        case (op_w)
            OP_SUB: begin
                alu_w     = diff_w;
                alu_ovf_w = (A[WIDTH-1] != B[WIDTH-1]) && (diff_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: begin
                alu_w     = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
                alu_ovf_w = 1'b0;
            end
            OP_NOT: begin
                alu_w     = ~A;
                alu_ovf_w = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        sh_d     = sh_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
`ifdef ULA_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op_w)
                        OP_SLL, OP_SRL: begin
                            if (shamt_w == '0) begin
                                result_d = A;
                                zero_d   = (A == '0);
                                ovf_d    = 1'b0;
                                done_d   = 1'b1;
                                state_d  = S_FIN;
                            end else begin
                                sh_d    = A;
                                dir_d   = (op_w == OP_SRL);
                                cnt_d   = CNT_W'(shamt_w);
                                busy_d  = 1'b1;
                                state_d = S_SHIFT;
                            end
                        end
`ifdef ULA_MUL_EN
                        OP_MUL: begin
                            acc_d    = '0;
                            mcand_d  = A;
                            mplier_d = B;
                            cnt_d    = CNT_W'(WIDTH);
                            busy_d   = 1'b1;
                            state_d  = S_MUL;
                        end
`endif
                        default: begin
                            result_d = alu_w;
                            zero_d   = (alu_w == '0);
                            ovf_d    = alu_ovf_w;
                            done_d   = 1'b1;
                            state_d  = S_FIN;
                        end
                    endcase
                end
            end
            S_SHIFT: begin
                sh_d  = sh_next_w;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = sh_next_w;
                    zero_d   = (sh_next_w == '0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_FIN;
                end else begin
                    busy_d = 1'b1;
                end
            end
`ifdef ULA_MUL_EN
            S_MUL: begin
                acc_d    = acc_next_w;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    result_d = acc_next_w;
                    zero_d   = (acc_next_w == '0);
                    ovf_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_FIN;
                end else begin
                    busy_d = 1'b1;
                end
            end
`endif
            // FIN lasts exactly one cycle; a start seen here is dropped.
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sh_q     <= '0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef ULA_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sh_q     <= sh_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
`ifdef ULA_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed self-checking bench for ula_multiciclo at WIDTH=8.
// Expectations follow whichever build is compiled (ULA_MUL_EN defined or not).
`default_nettype none

module tb_ula_multiciclo;

    logic       clock;
    logic       reset;
    logic       start;
    logic [1:0] ULAOp;
    logic       Funct;
    logic       Ext;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] result;
    logic       zero;
    logic       overflow;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    ula_multiciclo #(.WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .ULAOp    (ULAOp),
        .Funct    (Funct),
        .Ext      (Ext),
        .A        (A),
        .B        (B),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Launch one operation and sample at negedges until done or timeout (dcyc=-1).
    task automatic run_op(input logic [1:0] op, input logic f, input logic e,
                          input logic [7:0] a, input logic [7:0] b,
                          output int dcyc, output int bfirst, output int blast,
                          output int bcount, output bit both);
        dcyc = -1; bfirst = 0; blast = 0; bcount = 0; both = 1'b0;
        @(negedge clock);
        ULAOp = op; Funct = f; Ext = e; A = a; B = b; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (busy === 1'b1) begin
                if (bcount == 0) bfirst = k;
                blast = k;
                bcount++;
            end
            if (busy === 1'b1 && done === 1'b1) both = 1'b1;
            if (done === 1'b1) begin
                dcyc = k;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; ULAOp = 2'b00; Funct = 1'b0; Ext = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({result, zero, overflow, busy, done} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got result=%h z=%b v=%b busy=%b done=%b, want all zero",
                     result, zero, overflow, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_add_overflow;
        int d, bf, bl, bc; bit both;
        run_op(2'b00, 1'b0, 1'b0, 8'h7F, 8'h01, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 1 || bc !== 0) begin
            n_fail++;
            $display("FAIL add_timing: got done_cycle=%0d busy_cycles=%0d, want 1 and 0", d, bc);
        end
        n_checks++;
        if (result !== 8'h80 || overflow !== 1'b1 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ovf: got result=%h v=%b z=%b, want 80 1 0", result, overflow, zero);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b one cycle after done, want 0", done);
        end
    endtask

    task automatic test_sub_slt;
        int d, bf, bl, bc; bit both;
        run_op(2'b00, 1'b1, 1'b0, 8'h05, 8'h05, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 1 || result !== 8'h00 || zero !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_zero: got cyc=%0d result=%h z=%b v=%b, want 1 00 1 0", d, result, zero, overflow);
        end
        run_op(2'b01, 1'b0, 1'b0, 8'hFE, 8'h01, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 1 || result !== 8'h01 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL slt_signed: got cyc=%0d result=%h z=%b, want 1 01 0", d, result, zero);
        end
        run_op(2'b00, 1'b1, 1'b0, 8'h80, 8'h01, d, bf, bl, bc, both);
        n_checks++;
        if (result !== 8'h7F || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_ovf: got result=%h v=%b, want 7F 1", result, overflow);
        end
        run_op(2'b01, 1'b1, 1'b0, 8'h3C, 8'h00, d, bf, bl, bc, both);
        n_checks++;
        if (result !== 8'hC3 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL not_a: got result=%h v=%b, want C3 0", result, overflow);
        end
    endtask

    task automatic test_shift;
        int d, bf, bl, bc; bit both;
        run_op(2'b10, 1'b0, 1'b1, 8'h81, 8'h03, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 4 || bf !== 1 || bl !== 3 || bc !== 3 || both !== 1'b0) begin
            n_fail++;
            $display("FAIL sll_timing: got done=%0d busy=%0d..%0d n=%0d both=%b, want 4 1..3 3 0",
                     d, bf, bl, bc, both);
        end
        n_checks++;
        if (result !== 8'h08 || zero !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sll_result: got %h z=%b v=%b, want 08 0 0", result, zero, overflow);
        end
        run_op(2'b10, 1'b1, 1'b1, 8'hF0, 8'h04, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 5 || result !== 8'h0F) begin
            n_fail++;
            $display("FAIL srl_4: got cyc=%0d result=%h, want 5 0F", d, result);
        end
        run_op(2'b10, 1'b1, 1'b1, 8'hA5, 8'h08, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 1 || bc !== 0 || result !== 8'hA5) begin
            n_fail++;
            $display("FAIL srl_zero_amt: got cyc=%0d busy_n=%0d result=%h, want 1 0 A5", d, bc, result);
        end
        run_op(2'b10, 1'b1, 1'b1, 8'h01, 8'h01, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 2 || result !== 8'h00 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL srl_to_zero: got cyc=%0d result=%h z=%b, want 2 00 1", d, result, zero);
        end
    endtask

    task automatic test_mul;
        int d, bf, bl, bc; bit both;
        run_op(2'b11, 1'b0, 1'b1, 8'd13, 8'd11, d, bf, bl, bc, both);
`ifdef ULA_MUL_EN
        n_checks++;
        if (d !== 9 || bc !== 8 || both !== 1'b0 || result !== 8'h8F || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mul: got cyc=%0d busy_n=%0d both=%b result=%h v=%b, want 9 8 0 8F 0",
                     d, bc, both, result, overflow);
        end
`else
        n_checks++;
        if (d !== 1 || bc !== 0 || result !== 8'h18) begin
            n_fail++;
            $display("FAIL mul_as_add: got cyc=%0d busy_n=%0d result=%h, want 1 0 18", d, bc, result);
        end
`endif
        run_op(2'b11, 1'b1, 1'b1, 8'd13, 8'd11, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 1 || result !== 8'h18) begin
            n_fail++;
            $display("FAIL ext_11_f1_add: got cyc=%0d result=%h, want 1 18", d, result);
        end
    endtask

    task automatic test_legacy;
        int d, bf, bl, bc; bit both;
        run_op(2'b10, 1'b1, 1'b0, 8'd3, 8'd4, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 1 || result !== 8'd7) begin
            n_fail++;
            $display("FAIL legacy_10: got cyc=%0d result=%h, want 1 07", d, result);
        end
        run_op(2'b11, 1'b0, 1'b0, 8'hFF, 8'h01, d, bf, bl, bc, both);
        n_checks++;
        if (result !== 8'h00 || zero !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL legacy_11: got result=%h z=%b v=%b, want 00 1 0", result, zero, overflow);
        end
    endtask

    // Long op: MUL 13*11 when enabled, otherwise SLL 0x81 by 7.
    task automatic launch_long(output logic [7:0] exp_res, output int exp_cyc);
        @(negedge clock);
`ifdef ULA_MUL_EN
        ULAOp = 2'b11; Funct = 1'b0; Ext = 1'b1; A = 8'd13; B = 8'd11;
        exp_res = 8'h8F; exp_cyc = 9;
`else
        ULAOp = 2'b10; Funct = 1'b0; Ext = 1'b1; A = 8'h81; B = 8'h07;
        exp_res = 8'h80; exp_cyc = 8;
`endif
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_busy_ignore;
        logic [7:0] er; int ec; int d; int extra;
        launch_long(er, ec);
        d = -1; extra = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 2) begin
                ULAOp = 2'b00; Funct = 1'b0; Ext = 1'b0; A = 8'd1; B = 8'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                d = k;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
        n_checks++;
        if (d !== ec || result !== er) begin
            n_fail++;
            $display("FAIL busy_ignore: got cyc=%0d result=%h, want %0d %h", d, result, ec, er);
        end
        repeat (4) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0 || result !== er) begin
            n_fail++;
            $display("FAIL busy_ignore_after: got stray=%0d result=%h, want 0 %h", extra, result, er);
        end
    endtask

    task automatic test_back_to_back;
        int d, bf, bl, bc; bit both; int extra;
        run_op(2'b00, 1'b0, 1'b0, 8'd1, 8'd1, d, bf, bl, bc, both);
        ULAOp = 2'b00; Funct = 1'b0; Ext = 1'b0; A = 8'd5; B = 8'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        extra = 0;
        repeat (3) begin
            if (done === 1'b1) extra++;
            @(negedge clock);
        end
        n_checks++;
        if (d !== 1 || extra !== 0 || result !== 8'd2) begin
            n_fail++;
            $display("FAIL fin_start_ignored: got cyc=%0d stray=%0d result=%h, want 1 0 02", d, extra, result);
        end
    endtask

    task automatic test_reset_midop;
        logic [7:0] er; int ec; int d, bf, bl, bc; bit both; int extra;
        launch_long(er, ec);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || result !== 8'h00 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop: got busy=%b result=%h done=%b, want 0 00 0", busy, result, done);
        end
        reset = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL reset_abort: got %0d cycles with busy/done after reset, want 0", extra);
        end
        run_op(2'b00, 1'b0, 1'b0, 8'd2, 8'd2, d, bf, bl, bc, both);
        n_checks++;
        if (d !== 1 || result !== 8'd4 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL add_after_reset: got cyc=%0d result=%h z=%b, want 1 04 0", d, result, zero);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_slt();
        test_shift();
        test_mul();
        test_legacy();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
